// File: rtl/bof_pkg.sv
// Shared types and constants for the heap-overflow range buffer.
// The overflow-detection unit imports the same package.
//   bof_range_t : one stored interval {valid, first, last}
//   BOF_DEPTH   : default number of interval entries
//   BOF_ADDR_W  : default address width
package bof_pkg;

  localparam int unsigned BOF_DEPTH  = 8;
  localparam int unsigned BOF_ADDR_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [BOF_ADDR_W-1:0] first;
    logic [BOF_ADDR_W-1:0] last;
  } bof_range_t;

endpackage

// File: rtl/bof_range_cmp.sv
// Per-entry inclusive-bounds comparator.
// Ports:
//   valid_i : entry holds an interval
//   first_i : inclusive lower bound
//   last_i  : inclusive upper bound
//   addr_i  : query address
//   hit_o   : valid_i && first_i <= addr_i <= last_i (unsigned)
module bof_range_cmp #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] first_i,
  input  logic [ADDR_W-1:0] last_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o
);

  assign hit_o = valid_i && (first_i <= addr_i) && (addr_i <= last_i);

endmodule

// File: rtl/bof_range_buffer.sv
// Circular store of detected heap-overflow address intervals with a
// same-cycle combinational "address in any interval" query.
// Optional feature macro: BOF_RANGE_MERGE_EN -- when defined, a valid write
// that overlaps or abuts the most recent entry extends that entry instead of
// allocating a new one.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   rst_us_i           : synchronous clear of all entries (wins over a write)
//   en_write_i         : write strobe for [addr_first_i, addr_last_i]
//   find_addr_i        : query address
//   addr_in_range_o    : query hit (combinational, pre-write contents)
//   hit_idx_o          : lowest hitting entry index, 0 when no hit
//   read_o, read2_o    : bounds of the most recently written entry
//   count_o, full_o    : number of valid entries, buffer full
//   wrap_o             : pulse, a write overwrote a valid entry
//   bad_range_o        : pulse, write rejected because first > last
module bof_range_buffer
  import bof_pkg::*;
#(
  parameter int unsigned DEPTH  = BOF_DEPTH,
  parameter int unsigned ADDR_W = BOF_ADDR_W,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rst_us_i,
  input  logic              en_write_i,
  input  logic [ADDR_W-1:0] addr_first_i,
  input  logic [ADDR_W-1:0] addr_last_i,
  input  logic [ADDR_W-1:0] find_addr_i,
  output logic              addr_in_range_o,
  output logic [IDX_W-1:0]  hit_idx_o,
  output logic [31:0]       read_o,
  output logic [31:0]       read2_o,
  output logic [IDX_W:0]    count_o,
  output logic              full_o,
  output logic              wrap_o,
  output logic              bad_range_o
);

  localparam logic [IDX_W:0]   CountMax = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] PtrOne   = IDX_W'(1);
  localparam logic [IDX_W:0]   CountOne = (IDX_W+1)'(1);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] first_q [DEPTH];
  logic [ADDR_W-1:0] last_q  [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [IDX_W:0]    count_q;
  logic [ADDR_W-1:0] read_q, read2_q;
  logic              wrap_q, bad_q;

  logic [DEPTH-1:0]  hit;
  logic              range_ok, do_write, do_merge, merge_ok;
  logic [IDX_W-1:0]  prev_ptr, wr_idx;
  logic [ADDR_W-1:0] new_first, new_last;

  // Lookup
  for (genvar e = 0; e < DEPTH; e++) begin : g_cmp
    bof_range_cmp #(
      .ADDR_W(ADDR_W)
    ) u_cmp (
      .valid_i(valid_q[e]),
      .first_i(first_q[e]),
      .last_i (last_q[e]),
      .addr_i (find_addr_i),
      .hit_o  (hit[e])
    );
  end

  always_comb begin
    hit_idx_o = '0;
    // Descending scan so the lowest hitting index is the last assignment.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx_o = IDX_W'(i);
    end
  end

  assign addr_in_range_o = |hit;

  // Write decode
  always_comb begin
    range_ok = addr_first_i <= addr_last_i;
    do_write = en_write_i && range_ok && !rst_us_i;
    prev_ptr = wr_ptr_q - PtrOne;
`ifdef BOF_RANGE_MERGE_EN
    // Widened compare so last+1 at the maximum address does not wrap to 0.
    merge_ok = valid_q[prev_ptr] &&
               ({1'b0, addr_first_i} <= ({1'b0, last_q[prev_ptr]} + (ADDR_W+1)'(1))) &&
               ({1'b0, first_q[prev_ptr]} <= ({1'b0, addr_last_i} + (ADDR_W+1)'(1)));
`else
    merge_ok = 1'b0;
`endif
    do_merge  = do_write && merge_ok;
    wr_idx    = do_merge ? prev_ptr : wr_ptr_q;
    new_first = (do_merge && (first_q[prev_ptr] < addr_first_i)) ? first_q[prev_ptr]
                                                                   : addr_first_i;
    new_last  = (do_merge && (last_q[prev_ptr] > addr_last_i)) ? last_q[prev_ptr]
                                                                : addr_last_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        first_q[i] <= '0;
        last_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      count_q  <= '0;
      read_q   <= '0;
      read2_q  <= '0;
      wrap_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else if (rst_us_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      read_q   <= '0;
      read2_q  <= '0;
      wrap_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      wrap_q <= do_write && !do_merge && valid_q[wr_ptr_q];
      bad_q  <= en_write_i && !range_ok;
      if (do_write) begin
        valid_q[wr_idx] <= 1'b1;
        first_q[wr_idx] <= new_first;
        last_q[wr_idx]  <= new_last;
        read_q          <= new_first;
        read2_q         <= new_last;
        if (!do_merge) begin
          wr_ptr_q <= wr_ptr_q + PtrOne;
          if (count_q != CountMax) count_q <= count_q + CountOne;
        end
      end
    end
  end

  if (ADDR_W >= 32) begin : g_rd_trunc
    assign read_o  = read_q[31:0];
    assign read2_o = read2_q[31:0];
  end else begin : g_rd_ext
    assign read_o  = {{(32-ADDR_W){1'b0}}, read_q};
    assign read2_o = {{(32-ADDR_W){1'b0}}, read2_q};
  end

  assign count_o     = count_q;
  assign full_o      = count_q == CountMax;
  assign wrap_o      = wrap_q;
  assign bad_range_o = bad_q;

endmodule

// File: tb/tb_bof_range_buffer.sv
// Directed self-checking bench for bof_range_buffer (default parameters).
module tb_bof_range_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rst_us_i;
  logic        en_write_i;
  logic [31:0] addr_first_i, addr_last_i, find_addr_i;
  logic        addr_in_range_o;
  logic [2:0]  hit_idx_o;
  logic [31:0] read_o, read2_o;
  logic [3:0]  count_o;
  logic        full_o, wrap_o, bad_range_o;

  int tests = 0;
  int fails = 0;

  bof_range_buffer #(
    .DEPTH (8),
    .ADDR_W(32)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rst_us_i       (rst_us_i),
    .en_write_i     (en_write_i),
    .addr_first_i   (addr_first_i),
    .addr_last_i    (addr_last_i),
    .find_addr_i    (find_addr_i),
    .addr_in_range_o(addr_in_range_o),
    .hit_idx_o      (hit_idx_o),
    .read_o         (read_o),
    .read2_o        (read2_o),
    .count_o        (count_o),
    .full_o         (full_o),
    .wrap_o         (wrap_o),
    .bad_range_o    (bad_range_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic query(input logic [31:0] a);
    find_addr_i = a;
    #1;
  endtask

  task automatic write(input logic [31:0] f, input logic [31:0] l);
    en_write_i   = 1'b1;
    addr_first_i = f;
    addr_last_i  = l;
    tick();
    en_write_i   = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; rst_us_i = 1'b0; en_write_i = 1'b0;
    addr_first_i = '0; addr_last_i = '0; find_addr_i = 32'h1000;
    #12;
    check("rst_in_range", addr_in_range_o, 0);
    check("rst_count", count_o, 0);
    check("rst_read", read_o, 0);
    check("rst_read2", read2_o, 0);
    check("rst_pulses", {wrap_o, bad_range_o, full_o}, 0);
    rst_ni = 1'b1;
    tick();

    // Basic write and inclusive bounds
    write(32'h2000, 32'h2040);
    check("w1_read", read_o, 32'h2000);
    check("w1_read2", read2_o, 32'h2040);
    check("w1_count", count_o, 1);
    query(32'h2000); check("q_2000", addr_in_range_o, 1);
    query(32'h2040); check("q_2040", addr_in_range_o, 1);
    query(32'h2041); check("q_2041", addr_in_range_o, 0);
    query(32'h1fff); check("q_1fff", addr_in_range_o, 0);

    // Same-cycle write and lookup sees pre-write contents
    en_write_i = 1'b1; addr_first_i = 32'h3000; addr_last_i = 32'h3010;
    query(32'h3008);
    check("same_cyc_pre", addr_in_range_o, 0);
    tick();
    en_write_i = 1'b0;
    query(32'h3008);
    check("same_cyc_post", addr_in_range_o, 1);
    check("same_cyc_idx", hit_idx_o, 1);
    check("same_cyc_count", count_o, 2);

    // User clear
    rst_us_i = 1'b1; tick(); rst_us_i = 1'b0;
    check("clr_count", count_o, 0);
    check("clr_read", read_o, 0);
    query(32'h2000); check("clr_miss", addr_in_range_o, 0);

    // DEPTH+1 writes: only the last one overwrites a valid entry
    for (int k = 0; k < 9; k++) begin
      write(32'h100 * k, 32'h100 * k + 32'hF);
      check($sformatf("wrap_k%0d", k), wrap_o, (k == 8) ? 1 : 0);
    end
    tick();
    check("wrap_drop", wrap_o, 0);
    check("full_count", count_o, 8);
    check("full_flag", full_o, 1);
    query(32'h0005); check("q_0005", addr_in_range_o, 0);
    query(32'h0805); check("q_0805", addr_in_range_o, 1);
    check("q_0805_idx", hit_idx_o, 0);
    query(32'h0705); check("q_0705_idx", hit_idx_o, 7);
    query(32'h0810); check("q_0810_idx", hit_idx_o, 0);

    // Rejected write
    write(32'h50, 32'h40);
    check("bad_pulse", bad_range_o, 1);
    check("bad_count", count_o, 8);
    check("bad_wrap", wrap_o, 0);
    check("bad_read", read_o, 32'h800);
    tick();
    check("bad_drop", bad_range_o, 0);

    // Clear wins over simultaneous write
    rst_us_i = 1'b1; write(32'h60, 32'h70); rst_us_i = 1'b0;
    check("clrw_count", count_o, 0);
    check("clrw_pulses", {wrap_o, bad_range_o}, 0);
    check("clrw_read2", read2_o, 0);
    query(32'h0805); check("clrw_q805", addr_in_range_o, 0);
    query(32'h0065); check("clrw_q65", addr_in_range_o, 0);

`ifdef BOF_RANGE_MERGE_EN
    write(32'h400, 32'h40F);
    write(32'h410, 32'h41F);
    check("merge_count", count_o, 1);
    check("merge_read", read_o, 32'h400);
    check("merge_read2", read2_o, 32'h41F);
    check("merge_wrap", wrap_o, 0);
    query(32'h418); check("merge_q418", addr_in_range_o, 1);
    rst_us_i = 1'b1; tick(); rst_us_i = 1'b0;
`endif

    // Single-address interval, then the full address space
    write(32'h77, 32'h77);
    query(32'h77); check("single_hit", addr_in_range_o, 1);
    query(32'h76); check("single_lo", addr_in_range_o, 0);
    query(32'h78); check("single_hi", addr_in_range_o, 0);
    write(32'h0, 32'hFFFF_FFFF);
    query(32'hFFFF_FFFF); check("all_max", addr_in_range_o, 1);
    query(32'h0); check("all_zero", addr_in_range_o, 1);
    query(32'h77); check("all_idx77", hit_idx_o, 0);
    check("all_read2", read2_o, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
